rep_cmps_sequencer: RTL

- Micro-op sequencer for CMPS and REP/REPE/REPNE CMPS in the decode stage.
- Splits each string-compare iteration into two uops:
  - first uop: load from DS:ESI;
  - second uop: load from ES:EDI, then compare.
- Drives the control-store bits is_cmps_first_uop_all, is_cmps_second_uop_all and is_first_of_repne for each uop.
- Holds the front end stalled until the repeat terminates, using the ECX count and the ZF returned from writeback.

---
 rtl/rep_cmps_sequencer_pkg.sv | 26 ++
 rtl/rep_cmps_sequencer_if.sv | 34 +++
 rtl/rep_cmps_sequencer_term_check.sv | 22 ++
 rtl/rep_cmps_sequencer.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/rep_cmps_sequencer_pkg.sv
// Shared encodings and types for the CMPS / REP CMPS micro-op sequencer.
// Also used by rep_term_check so a later SCAS sequencer can pick it up unchanged.
package rep_cmps_sequencer_pkg;

    localparam int unsigned CNT_W = 32;

    localparam logic [1:0] REP_NONE = 2'b00;
    localparam logic [1:0] REP_E    = 2'b01;
    localparam logic [1:0] REP_NE   = 2'b10;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_FIRST      = 3'd1,
        ST_SECOND     = 3'd2,
        ST_WAIT_FLAGS = 3'd3,
        ST_FINISH     = 3'd4
    } state_t;

    function automatic logic is_rep(input logic [1:0] kind);
        return (kind != REP_NONE);
    endfunction

endpackage

// File: rtl/rep_cmps_sequencer_if.sv
// Decode-side, uop-issue and writeback-flag signals of the CMPS sequencer.
// The sequencer uses the slave view; whatever drives decode/writeback uses master.
interface rep_cmps_sequencer_if;
    import rep_cmps_sequencer_pkg::*;

    logic             flush;
    logic             instr_valid;
    logic [1:0]       rep_kind;
    logic [CNT_W-1:0] ecx_in;
    logic             uop_ready;
    logic             wb_flags_valid;
    logic             wb_zf;

    logic             uop_valid;
    logic             cs_is_cmps_first_uop_all;
    logic             cs_is_cmps_second_uop_all;
    logic             cs_is_first_of_repne;
    logic             ecx_dec;
    logic             decode_stall;
    logic             seq_done;

    modport slave (
        input  flush, instr_valid, rep_kind, ecx_in, uop_ready, wb_flags_valid, wb_zf,
        output uop_valid, cs_is_cmps_first_uop_all, cs_is_cmps_second_uop_all,
               cs_is_first_of_repne, ecx_dec, decode_stall, seq_done
    );

    modport master (
        output flush, instr_valid, rep_kind, ecx_in, uop_ready, wb_flags_valid, wb_zf,
        input  uop_valid, cs_is_cmps_first_uop_all, cs_is_cmps_second_uop_all,
               cs_is_first_of_repne, ecx_dec, decode_stall, seq_done
    );

endinterface

// File: rtl/rep_cmps_sequencer_term_check.sv
// Repeat-termination rule for REP-prefixed string ops: count exhausted, or the
// ZF condition of REPE/REPNE failed on the iteration that just wrote back.
module rep_term_check
    import rep_cmps_sequencer_pkg::*;
(
    input  logic [1:0] rep_kind,
    input  logic       count_is_zero,
    input  logic       zf,
    output logic       terminate
);

    // Count exhaustion always ends the loop; the prefix adds its ZF exit.
    always_comb begin
        terminate = count_is_zero;
        case (rep_kind)
            REP_E:   terminate = count_is_zero | ~zf;
            REP_NE:  terminate = count_is_zero | zf;
            default: terminate = count_is_zero;
        endcase
    end

endmodule

// File: rtl/rep_cmps_sequencer.sv
// Decode-stage sequencer splitting each CMPS iteration into a DS:ESI load uop
// and an ES:EDI load+compare uop, holding decode until the repeat terminates.
module rep_cmps_sequencer
    import rep_cmps_sequencer_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    rep_cmps_sequencer_if.slave  bus
);

    state_t           r_state;
    logic [1:0]       r_rep_kind;
    logic [CNT_W-1:0] r_count;
    logic             r_first_iter;
    logic             r_uop_valid;
    logic             r_first_uop;
    logic             r_second_uop;
    logic             r_first_of_repne;
    logic             r_seq_done;

    logic             w_is_rep;
    logic             w_count_is_zero;
    logic             w_start_zero;
    logic             w_terminate;

    assign w_is_rep        = is_rep(r_rep_kind);
    assign w_count_is_zero = (r_count == CNT_ZERO);
    assign w_start_zero    = is_rep(bus.rep_kind) && (bus.ecx_in == CNT_ZERO);

    rep_term_check u_term (
        .rep_kind      (r_rep_kind),
        .count_is_zero (w_count_is_zero),
        .zf            (bus.wb_zf),
        .terminate     (w_terminate)
    );

    assign bus.uop_valid                 = r_uop_valid;
    assign bus.cs_is_cmps_first_uop_all  = r_first_uop;
    assign bus.cs_is_cmps_second_uop_all = r_second_uop;
    assign bus.cs_is_first_of_repne      = r_first_of_repne;
    assign bus.seq_done                  = r_seq_done;

    // ecx_dec tracks the acceptance handshake itself so a coincident flush cannot hide it.
    assign bus.ecx_dec      = (r_state == ST_SECOND) && bus.uop_ready && w_is_rep;
    assign bus.decode_stall = (r_state == ST_IDLE) ? bus.instr_valid
                            : ((r_state == ST_FIRST) || (r_state == ST_SECOND) ||
                               (r_state == ST_WAIT_FLAGS));

    // Sequencer FSM; uop outputs are registered alongside the state they describe.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state          <= ST_IDLE;
            r_rep_kind       <= REP_NONE;
            r_count          <= CNT_ZERO;
            r_first_iter     <= 1'b0;
            r_uop_valid      <= 1'b0;
            r_first_uop      <= 1'b0;
            r_second_uop     <= 1'b0;
            r_first_of_repne <= 1'b0;
            r_seq_done       <= 1'b0;
        end else if (bus.flush) begin
            r_state          <= ST_IDLE;
            r_uop_valid      <= 1'b0;
            r_first_uop      <= 1'b0;
            r_second_uop     <= 1'b0;
            r_first_of_repne <= 1'b0;
            r_seq_done       <= 1'b0;
        end else begin
            r_seq_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.instr_valid && w_start_zero) begin
                        r_state    <= ST_FINISH;
                        r_seq_done <= 1'b1;
                    end else if (bus.instr_valid) begin
                        r_rep_kind       <= bus.rep_kind;
                        r_count          <= bus.ecx_in;
                        r_first_iter     <= 1'b1;
                        r_state          <= ST_FIRST;
                        r_uop_valid      <= 1'b1;
                        r_first_uop      <= 1'b1;
                        r_first_of_repne <= is_rep(bus.rep_kind);
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_FIRST: begin
                    if (bus.uop_ready) begin
                        r_state      <= ST_SECOND;
                        r_first_uop  <= 1'b0;
                        r_second_uop <= 1'b1;
                    end else begin
                        r_state <= ST_FIRST;
                    end
                end
                ST_SECOND: begin
                    if (bus.uop_ready) begin
                        r_uop_valid      <= 1'b0;
                        r_second_uop     <= 1'b0;
                        r_first_of_repne <= 1'b0;
                        if (w_is_rep) begin
                            r_count      <= r_count - CNT_ONE;
                            r_first_iter <= 1'b0;
                            r_state      <= ST_WAIT_FLAGS;
                        end else begin
                            r_state    <= ST_FINISH;
                            r_seq_done <= 1'b1;
                        end
                    end else begin
                        r_state <= ST_SECOND;
                    end
                end
                ST_WAIT_FLAGS: begin
                    if (bus.wb_flags_valid && w_terminate) begin
                        r_state    <= ST_FINISH;
                        r_seq_done <= 1'b1;
                    end else if (bus.wb_flags_valid) begin
                        r_state          <= ST_FIRST;
                        r_uop_valid      <= 1'b1;
                        r_first_uop      <= 1'b1;
                        r_first_of_repne <= r_first_iter & w_is_rep;
                    end else begin
                        r_state <= ST_WAIT_FLAGS;
                    end
                end
                ST_FINISH: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state          <= ST_IDLE;
                    r_uop_valid      <= 1'b0;
                    r_first_uop      <= 1'b0;
                    r_second_uop     <= 1'b0;
                    r_first_of_repne <= 1'b0;
                end
            endcase
        end
    end

endmodule
